// File: rtl/key_beep_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : key_beep_pkg
//  Purpose  : Shared FSM state encoding, beep-count constants and the helper
//             that turns a granted request into its beeps_left start value.
//  Config   : KEY_BEEP_LONG_PRESS_EN (long-press 3-beep pattern, see top)
//  Revision : 1.0  initial release
// ============================================================================
package key_beep_pkg;

    // Scheduler FSM states, fixed 2-bit encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ON   = 2'd1;
    localparam state_t ST_OFF  = 2'd2;

    // Number of beeps per request type.
    localparam int NB_KEY0 = 1;
    localparam int NB_KEY1 = 2;
    localparam int NB_LONG = 3;

    // beeps_left is loaded with N-1 because the first burst starts immediately.
    function automatic logic [1:0] beeps_left_init(input logic is_key1,
                                                   input logic is_long);
        logic [1:0] n;
        if (is_long) begin
            n = 2'(NB_LONG - 1);
        end else if (is_key1) begin
            n = 2'(NB_KEY1 - 1);
        end else begin
            n = 2'(NB_KEY0 - 1);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_press_det.sv
`default_nettype none
// ============================================================================
//  Module   : key_press_det
//  Purpose  : Per-key falling-edge detector on a debounced active-low level.
//             With KEY_BEEP_LONG_PRESS_EN it also measures hold time and
//             raises a sticky long flag plus one extra request per hold.
//  Config   : KEY_BEEP_LONG_PRESS_EN
//  Revision : 1.0  initial release
// ============================================================================
module key_press_det
`ifdef KEY_BEEP_LONG_PRESS_EN
#(
    parameter int LONG_CYC = 50000000
)
`endif
(
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_key_filter,
`ifdef KEY_BEEP_LONG_PRESS_EN
    input  logic i_long_clr,
    output logic o_long_q,
`endif
    output logic o_press
);

    logic r_key_d;
    logic w_edge;

    // Delayed key level; reset to released so reset release never looks like a press.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_key_d <= 1'b1;
        end else begin
            r_key_d <= i_key_filter;
        end
    end

    assign w_edge = r_key_d & ~i_key_filter;

`ifdef KEY_BEEP_LONG_PRESS_EN
    localparam int c_HOLD_W = $clog2(LONG_CYC + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(LONG_CYC);
    localparam logic [c_HOLD_W-1:0] c_HOLD_HIT = c_HOLD_W'(LONG_CYC - 1);

    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_long_q;
    logic                w_long_hit;

    // Hold counter: counts while pressed, parks at LONG_CYC so the hit fires once per hold.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_hold_cnt <= '0;
        end else if (i_key_filter) begin
            r_hold_cnt <= '0;
        end else if (r_hold_cnt != c_HOLD_MAX) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    assign w_long_hit = ~i_key_filter && (r_hold_cnt == c_HOLD_HIT);

    // Long flag: set by the hold hit, consumed when the scheduler grants this key.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_long_q <= 1'b0;
        end else if (w_long_hit) begin
            r_long_q <= 1'b1;
        end else if (i_long_clr) begin
            r_long_q <= 1'b0;
        end
    end

    assign o_long_q = r_long_q;
    assign o_press  = w_edge | w_long_hit;
`else
    assign o_press  = w_edge;
`endif

endmodule
`default_nettype wire

// File: rtl/key_beep_sched.sv
`default_nettype none
// ============================================================================
//  Module   : key_beep_sched
//  Purpose  : Shares one buzzer between two debounced active-low keys.
//             key0 press -> 1 beep, key1 press -> 2 beeps. One-deep request
//             queue per key, round-robin arbitration on contention, each
//             burst is ON_CYC clocks of tone followed by OFF_CYC of silence.
//  Config   : KEY_BEEP_LONG_PRESS_EN adds a LONG_CYC hold that queues a
//             3-beep pattern once per hold.
//  Revision : 1.0  initial release
// ============================================================================
module key_beep_sched
    import key_beep_pkg::*;
#(
    parameter int HALF_PER = 25000,
    parameter int ON_CYC   = 5000000,
    parameter int OFF_CYC  = 5000000
`ifdef KEY_BEEP_LONG_PRESS_EN
    ,
    parameter int LONG_CYC = 50000000
`endif
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] key_filter,
    output logic       beep,
    output logic       busy,
    output logic [1:0] grant,
    output logic [1:0] pend
);

    localparam int c_CYC_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int c_CYC_W   = $clog2(c_CYC_MAX + 1);
    localparam int c_TONE_W  = $clog2(HALF_PER + 1);

    localparam logic [c_CYC_W-1:0]  c_ON_LOAD   = c_CYC_W'(ON_CYC - 1);
    localparam logic [c_CYC_W-1:0]  c_OFF_LOAD  = c_CYC_W'(OFF_CYC - 1);
    localparam logic [c_TONE_W-1:0] c_TONE_LOAD = c_TONE_W'(HALF_PER - 1);

    state_t              r_state;
    logic [1:0]          r_grant;
    logic [1:0]          r_pend;
    logic                r_rr;
    logic                r_beep;
    logic [1:0]          r_beeps_left;
    logic [c_CYC_W-1:0]  r_cyc_cnt;
    logic [c_TONE_W-1:0] r_tone_cnt;

    logic [1:0]          w_press;
    logic [1:0]          w_long_q;
    logic [1:0]          w_grant_sel;

    // Per-key press detection (and optional hold measurement).
    for (genvar k = 0; k < 2; k++) begin : g_key
`ifdef KEY_BEEP_LONG_PRESS_EN
        key_press_det #(
            .LONG_CYC     (LONG_CYC)
        ) u_det (
            .sys_clk      (sys_clk),
            .sys_rst_n    (sys_rst_n),
            .i_key_filter (key_filter[k]),
            .i_long_clr   (w_grant_sel[k]),
            .o_long_q     (w_long_q[k]),
            .o_press      (w_press[k])
        );
`else
        key_press_det u_det (
            .sys_clk      (sys_clk),
            .sys_rst_n    (sys_rst_n),
            .i_key_filter (key_filter[k]),
            .o_press      (w_press[k])
        );
        assign w_long_q[k] = 1'b0;
`endif
    end

    // Arbiter: only decides in IDLE; on contention the key that did not win last time goes.
    always_comb begin
        w_grant_sel = 2'b00;
        if (r_state == ST_IDLE) begin
            if (r_pend == 2'b11) begin
                w_grant_sel = r_rr ? 2'b01 : 2'b10;
            end else begin
                w_grant_sel = r_pend;
            end
        end
    end

    // Request flags: a new press wins over the grant clear, so a re-press in service re-queues.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_pend <= 2'b00;
        end else begin
            r_pend <= w_press | (r_pend & ~w_grant_sel);
        end
    end

    // Burst sequencer and tone generator; both counters reload on every ON entry.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= 2'b00;
            r_rr         <= 1'b0;
            r_beep       <= 1'b0;
            r_beeps_left <= 2'd0;
            r_cyc_cnt    <= '0;
            r_tone_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_sel != 2'b00) begin
                        r_state      <= ST_ON;
                        r_grant      <= w_grant_sel;
                        if (r_pend == 2'b11) begin
                            r_rr <= w_grant_sel[1];
                        end
                        r_beeps_left <= beeps_left_init(w_grant_sel[1],
                                                        |(w_grant_sel & w_long_q));
                        r_cyc_cnt    <= c_ON_LOAD;
                        r_tone_cnt   <= c_TONE_LOAD;
                        r_beep       <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (r_cyc_cnt == '0) begin
                        r_state   <= ST_OFF;
                        r_cyc_cnt <= c_OFF_LOAD;
                        r_beep    <= 1'b0;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt - 1'b1;
                        if (r_tone_cnt == '0) begin
                            r_beep     <= ~r_beep;
                            r_tone_cnt <= c_TONE_LOAD;
                        end else begin
                            r_tone_cnt <= r_tone_cnt - 1'b1;
                        end
                    end
                end
                ST_OFF: begin
                    if (r_cyc_cnt == '0) begin
                        if (r_beeps_left != 2'd0) begin
                            r_state      <= ST_ON;
                            r_beeps_left <= r_beeps_left - 2'd1;
                            r_cyc_cnt    <= c_ON_LOAD;
                            r_tone_cnt   <= c_TONE_LOAD;
                            r_beep       <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_grant <= 2'b00;
                        end
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= 2'b00;
                    r_beep  <= 1'b0;
                end
            endcase
        end
    end

    assign beep  = r_beep;
    assign busy  = (r_state != ST_IDLE);
    assign grant = r_grant;
    assign pend  = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_key_beep_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_beep_sched
//  Purpose  : Self-checking bench for key_beep_sched (HALF_PER=2, ON_CYC=8,
//             OFF_CYC=4). A pattern-level model predicts beep/busy/grant/pend
//             every cycle; directed literal checks pin the model itself.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_beep_sched;

    localparam int HALF = 2;
    localparam int ON   = 8;
    localparam int OFF  = 4;
    localparam int PER  = ON + OFF;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [1:0] key_filter;
    logic       beep;
    logic       busy;
    logic [1:0] grant;
    logic [1:0] pend;

    int n_checks = 0;
    int n_errors = 0;

    key_beep_sched #(
`ifdef KEY_BEEP_LONG_PRESS_EN
        .LONG_CYC   (20),
`endif
        .HALF_PER   (HALF),
        .ON_CYC     (ON),
        .OFF_CYC    (OFF)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_filter (key_filter),
        .beep       (beep),
        .busy       (busy),
        .grant      (grant),
        .pend       (pend)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- pattern-level model ----------------
    // A served request is a pattern starting at cycle m_start with m_n bursts;
    // outputs follow from the offset into that pattern.
    int         cyc      = 0;
    logic [1:0] m_kd     = 2'b11;
    logic [1:0] m_pend   = 2'b00;
    logic       m_rr     = 1'b0;
    bit         m_active = 1'b0;
    int         m_start  = 0;
    int         m_n      = 0;
    int         m_key    = 0;
    bit         m_valid  = 1'b0;

    task automatic model_step();
        logic [1:0] press;
        logic [1:0] gnt;
        bit         was_active;
        cyc++;
        m_valid = 1'b1;
        if (!sys_rst_n) begin
            m_kd     = 2'b11;
            m_pend   = 2'b00;
            m_rr     = 1'b0;
            m_active = 1'b0;
            return;
        end
        press      = m_kd & ~key_filter;
        m_kd       = key_filter;
        gnt        = 2'b00;
        was_active = m_active;
        if (was_active) begin
            if (cyc == m_start + m_n * PER) m_active = 1'b0;
        end else if (m_pend != 2'b00) begin
            if (m_pend == 2'b11) begin
                m_key = (m_rr == 1'b0) ? 1 : 0;
                m_rr  = (m_key == 1);
            end else begin
                m_key = m_pend[1] ? 1 : 0;
            end
            m_active = 1'b1;
            m_start  = cyc;
            m_n      = (m_key == 1) ? 2 : 1;
            gnt      = 2'(1 << m_key);
        end
        m_pend = press | (m_pend & ~gnt);
    endtask

    function automatic logic exp_beep();
        int p;
        if (!m_active) return 1'b0;
        p = (cyc - m_start) % PER;
        return (p < ON) && (((p / HALF) % 2) == 0);
    endfunction

    initial forever begin
        @(posedge sys_clk);
        model_step();
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(posedge sys_clk);
        #1;
        if (m_valid) begin
            chk("model_beep",  {7'd0, beep}, {7'd0, exp_beep()});
            chk("model_busy",  {7'd0, busy}, {7'd0, m_active});
            chk("model_grant", {6'd0, grant}, m_active ? 8'(1 << m_key) : 8'd0);
            chk("model_pend",  {6'd0, pend}, {6'd0, m_pend});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_keys(input logic [1:0] v);
        @(negedge sys_clk);
        key_filter = v;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", k);
        end
        repeat (2) tick();
    endtask

    initial begin
        logic [7:0] seq;
        int         cnt;
        sys_rst_n  = 1'b0;
        key_filter = 2'b11;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_beep",  {7'd0, beep}, 8'd0);
        chk("rst_busy",  {7'd0, busy}, 8'd0);
        chk("rst_pend",  {6'd0, pend}, 8'd0);
        chk("rst_grant", {6'd0, grant}, 8'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (5) tick();
        chk("no_spurious_pend", {6'd0, pend}, 8'd0);
        chk("no_spurious_busy", {7'd0, busy}, 8'd0);

        // key0 low for 3 clocks starting at cycle T
        set_keys(2'b10);
        tick();
        chk("k0_pend_T1", {6'd0, pend}, 8'h01);
        tick();
        chk("k0_grant_T2", {6'd0, grant}, 8'h01);
        seq[7] = beep;
        tick();
        seq[6] = beep;
        set_keys(2'b11);
        for (int i = 5; i >= 0; i--) begin
            tick();
            seq[i] = beep;
        end
        chk("k0_beep_seq", seq, 8'b1100_1100);
        repeat (4) tick();
        chk("k0_busy_T13", {7'd0, busy}, 8'd1);
        tick();
        chk("k0_busy_T14", {7'd0, busy}, 8'd0);
        wait_idle();

        // key1: two bursts, 24 busy clocks
        set_keys(2'b01);
        tick();
        set_keys(2'b11);
        tick();
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("k1_busy_len", 8'(cnt), 8'd24);
        wait_idle();

        // both keys together, rr=0 -> key1 first, then key0
        set_keys(2'b00);
        tick();
        set_keys(2'b11);
        tick();
        chk("both1_first", {6'd0, grant}, 8'h02);
        repeat (25) tick();
        chk("both1_second", {6'd0, grant}, 8'h01);
        wait_idle();

        // both again -> key0 first
        set_keys(2'b00);
        tick();
        set_keys(2'b11);
        tick();
        chk("both2_first", {6'd0, grant}, 8'h01);
        repeat (13) tick();
        chk("both2_second", {6'd0, grant}, 8'h02);
        wait_idle();

        // key0 re-pressed during its own ON burst
        set_keys(2'b10);
        tick();
        tick();
        set_keys(2'b11);
        tick();
        tick();
        set_keys(2'b10);
        tick();
        set_keys(2'b11);
        repeat (5) tick();
        chk("repress_pend_held", {6'd0, pend}, 8'h01);
        chk("repress_busy", {7'd0, busy}, 8'd1);
        repeat (5) tick();
        chk("repress_grant2", {6'd0, grant}, 8'h01);
        chk("repress_beep2", {7'd0, beep}, 8'd1);
        chk("repress_pend_clr", {6'd0, pend}, 8'd0);
        wait_idle();

        // reset asserted mid-ON with a key0 request queued
        set_keys(2'b01);
        tick();
        set_keys(2'b11);
        tick();
        set_keys(2'b10);
        tick();
        chk("midrst_pend_before", {6'd0, pend}, 8'h01);
        chk("midrst_beep_before", {7'd0, beep}, 8'd1);
        @(negedge sys_clk);
        sys_rst_n  = 1'b0;
        key_filter = 2'b11;
        tick();
        chk("midrst_beep",  {7'd0, beep}, 8'd0);
        chk("midrst_busy",  {7'd0, busy}, 8'd0);
        chk("midrst_pend",  {6'd0, pend}, 8'd0);
        chk("midrst_grant", {6'd0, grant}, 8'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) tick();
        chk("midrst_no_spurious", {6'd0, pend}, 8'd0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
